csr_access_ctrl: RTL and testbench
==================================

CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, CSR address width.
REQ-002 Parameter DATA_W, default 32, CSR data width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  input  1  pipeline presents CSR instruction.
REQ-006 req_ready_o  output  1  controller can accept a request.
REQ-007 req_op_i  input  2  01=RW, 10=RS (set), 11=RC (clear), 00=reserved.
REQ-008 req_imm_i  input  1  immediate variant; operand is zero-extended req_zimm_i.
REQ-009 req_addr_i  input  ADDR_W  target CSR address.
REQ-010 req_rs1_i  input  DATA_W  register operand value.
REQ-011 req_zimm_i  input  5  immediate operand / rs1 index.
REQ-012 csr_raddr_o  output  ADDR_W  read address to CSR unit; combinational read data returns same cycle.
REQ-013 csr_rdata_i  input  DATA_W  read data from CSR unit.
REQ-014 csr_waddr_o  output  ADDR_W  write address to CSR unit.
REQ-015 csr_wdata_o  output  DATA_W  write data to CSR unit.
REQ-016 csr_wr_o  output  1  write strobe, one cycle per write.
REQ-017 rsp_valid_o  output  1  response available.
REQ-018 rsp_data_o  output  DATA_W  old CSR value for rd.
REQ-019 rsp_illegal_o  output  1  request was illegal; rd must not be written.
REQ-020 rsp_ready_i  input  1  pipeline consumes response.

Function
REQ-021 FSM states IDLE, READ, WRITE, RESP; IDLE->READ on req_valid_i&&req_ready_o; READ->WRITE; WRITE->RESP; RESP->IDLE on rsp_ready_i.
REQ-022 req_ready_o = 1 only in IDLE; request fields captured into internal registers on accept.
REQ-023 READ: csr_raddr_o = captured address; csr_rdata_i latched as old value at end of cycle.
REQ-024 Operand = imm ? {zeros, zimm} : rs1; new value RW: operand; RS: old|operand; RC: old&~operand.
REQ-025 Write suppressed when op is RS/RC and operand bits equal zero (zimm==0 for immediate, rs1 index==0 i.e. req_zimm_i==0 for register form).
REQ-026 WRITE: csr_wr_o = 1 for exactly this cycle unless suppressed or illegal; csr_waddr_o = captured address, csr_wdata_o = new value.
REQ-027 csr_wr_o = 0 in every state other than WRITE.
REQ-028 op 00 illegal: no write, response with rsp_illegal_o = 1, rsp_data_o = 0.
REQ-029 RESP: rsp_valid_o = 1, rsp_data_o/rsp_illegal_o stable until rsp_ready_i; fixed latency accept->rsp_valid_o = 3 cycles.
REQ-030 rsp_ready_i high in first RESP cycle: IDLE next cycle, new request accepted then (no back-to-back in same cycle).
REQ-031 rsp_ready_i ignored outside RESP; req_valid_i ignored outside IDLE.

Reset
REQ-032 rst_n low: state IDLE, req_ready_o = 1, csr_wr_o = 0, rsp_valid_o = 0, rsp_illegal_o = 0, all address/data outputs and captured registers 0.
REQ-033 Reset asserted in READ/WRITE/RESP aborts operation; no write issued after reset deassertion, pending response discarded.

Configuration
REQ-034 Macro CSR_CTRL_RO_CHECK_EN defined: address with req_addr_i[11:10]==2'b11 and a non-suppressed write is illegal: write blocked, rsp_illegal_o = 1, rsp_data_o = 0.
REQ-035 CSR_CTRL_RO_CHECK_EN undefined: no read-only check; write issued per REQ-026; rsp_illegal_o set only by REQ-028.

Verification
REQ-036 CSRRW addr 0x002, rs1=0x5, frm=0 -> write 0x5 to 0x002 in WRITE cycle, rsp_data_o=0x0 at cycle 3.
REQ-037 CSRRS addr 0x001, rs1=0x03, fflags=0x10 -> csr_wdata_o=0x13, rsp_data_o=0x10.
REQ-038 CSRRCI addr 0x003, zimm=0x1F, fcsr=0xFF -> csr_wdata_o=0xE0, rsp_data_o=0xFF.
REQ-039 CSRRS addr 0xC00, rs1 index 0 -> csr_wr_o never high, rsp_data_o=cycle count, rsp_illegal_o=0; CSRRW addr 0xC00 with macro -> no write, rsp_illegal_o=1; without macro -> write issued.
REQ-040 Hold rsp_ready_i low 5 cycles -> rsp_valid_o and rsp_data_o stable, req_ready_o=0 throughout; then ready -> IDLE next cycle.
REQ-041 Assert rst_n low during WRITE state -> csr_wr_o=0 immediately, IDLE after release, no subsequent write or response.

Source files
------------

// File: rtl/csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_access_ctrl
// Brief    : Sequences one CSR read-modify-write per request (read, write,
//            respond). Define CSR_CTRL_RO_CHECK_EN to reject writes to the
//            read-only CSR space (addr[11:10] == 2'b11, needs ADDR_W >= 12).
// Revision : 1.0 - initial release
// ============================================================================
module csr_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic              req_imm_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_rs1_i,
    input  logic [4:0]        req_zimm_i,
    output logic [ADDR_W-1:0] csr_raddr_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              csr_wr_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_illegal_o,
    input  logic              rsp_ready_i
);

    localparam logic [1:0] c_OP_RW = 2'b01;
    localparam logic [1:0] c_OP_RS = 2'b10;
    localparam logic [1:0] c_OP_RC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_op;
    logic                r_imm;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rs1;
    logic [4:0]          r_zimm;
    logic [DATA_W-1:0]   r_old;
    logic                r_illegal;

    logic [DATA_W-1:0]   w_operand;
    logic [DATA_W-1:0]   w_new;
    logic                w_suppress;
    logic                w_ro_hit;
    logic                w_illegal;
    logic                w_do_write;

    // Evaluated during READ, when csr_rdata_i holds the old value.
    always_comb begin
        w_operand  = r_imm ? {{(DATA_W-5){1'b0}}, r_zimm} : r_rs1;
        w_suppress = ((r_op == c_OP_RS) || (r_op == c_OP_RC)) && (r_zimm == 5'd0);
        case (r_op)
            c_OP_RW: w_new = w_operand;
            c_OP_RS: w_new = csr_rdata_i | w_operand;
            c_OP_RC: w_new = csr_rdata_i & ~w_operand;
            default: w_new = '0;
        endcase
`ifdef CSR_CTRL_RO_CHECK_EN
        w_ro_hit   = (r_addr[11:10] == 2'b11) && !w_suppress;
`else
        w_ro_hit   = 1'b0;
`endif
        w_illegal  = (r_op == 2'b00) || w_ro_hit;
        w_do_write = !w_illegal && !w_suppress;
    end

    assign csr_raddr_o = r_addr;
    assign csr_waddr_o = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_op          <= 2'b00;
            r_imm         <= 1'b0;
            r_addr        <= '0;
            r_rs1         <= '0;
            r_zimm        <= 5'd0;
            r_old         <= '0;
            r_illegal     <= 1'b0;
            req_ready_o   <= 1'b1;
            csr_wdata_o   <= '0;
            csr_wr_o      <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_illegal_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        r_op        <= req_op_i;
                        r_imm       <= req_imm_i;
                        r_addr      <= req_addr_i;
                        r_rs1       <= req_rs1_i;
                        r_zimm      <= req_zimm_i;
                        req_ready_o <= 1'b0;
                        r_state     <= S_READ;
                    end
                end
                S_READ: begin
                    r_old       <= csr_rdata_i;
                    r_illegal   <= w_illegal;
                    csr_wdata_o <= w_new;
                    csr_wr_o    <= w_do_write;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    csr_wr_o      <= 1'b0;
                    rsp_valid_o   <= 1'b1;
                    rsp_data_o    <= r_illegal ? '0 : r_old;
                    rsp_illegal_o <= r_illegal;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_access_ctrl
// Brief    : Self-checking bench for csr_access_ctrl with a transaction-level
//            reference model and a CSR storage array behind the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic        req_imm_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_rs1_i;
    logic [4:0]  req_zimm_i;
    logic [11:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_wr_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_illegal_o;
    logic        rsp_ready_i;

    int n_checks = 0;
    int n_errors = 0;

    csr_access_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_imm_i    (req_imm_i),
        .req_addr_i   (req_addr_i),
        .req_rs1_i    (req_rs1_i),
        .req_zimm_i   (req_zimm_i),
        .csr_raddr_o  (csr_raddr_o),
        .csr_rdata_i  (csr_rdata_i),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .csr_wr_o     (csr_wr_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_illegal_o(rsp_illegal_o),
        .rsp_ready_i  (rsp_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            1:       return 32'h0000_0010;
            2:       return 32'h0000_0000;
            3:       return 32'h0000_00FF;
            12'hC00: return 32'h0000_1234;
            default: return i * 32'h9E37_79B1 + 32'h5A5A;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // CSR unit: combinational read, write on strobe; restored while in reset.
    logic [31:0] csr_mem [0:4095];
    assign csr_rdata_i = csr_mem[csr_raddr_o];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= init_val(i);
        end else if (csr_wr_o) begin
            csr_mem[csr_waddr_o] <= csr_wdata_o;
        end
    end

    // Reference model: m_age counts cycles since accept (-1 = free to accept).
    logic [31:0] m_mem [0:4095];
    int          m_age;
    logic [11:0] m_addr;
    bit          m_wr;
    logic [31:0] m_new;
    logic [31:0] m_data;
    bit          m_illegal;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age = -1;
            m_wr  = 0;
            for (int i = 0; i < 4096; i++) m_mem[i] = init_val(i);
        end else if (m_age == -1) begin
            if (req_valid_i) begin
                logic [31:0] opnd, old;
                bit          supp, ro;
                opnd   = req_imm_i ? {27'd0, req_zimm_i} : req_rs1_i;
                old    = m_mem[req_addr_i];
                m_addr = req_addr_i;
                supp   = (req_op_i >= 2'd2) && (req_zimm_i == 5'd0);
`ifdef CSR_CTRL_RO_CHECK_EN
                ro     = (req_addr_i[11:10] == 2'b11) && !supp;
`else
                ro     = 0;
`endif
                m_illegal = (req_op_i == 2'd0) || ro;
                m_wr      = !m_illegal && !supp;
                m_data    = m_illegal ? 32'd0 : old;
                m_new     = (req_op_i == 2'd1) ? opnd :
                            (req_op_i == 2'd2) ? (old | opnd) : (old & ~opnd);
                m_age     = 1;
            end
        end else if (m_age < 3) begin
            if (m_age == 2 && m_wr) m_mem[m_addr] = m_new;
            m_age = m_age + 1;
        end else if (rsp_ready_i) begin
            m_age = -1;
        end
    end

    // Observations shared with the directed sequences.
    int          obs_wr_cnt = 0;
    logic [11:0] obs_waddr = '0;
    logic [31:0] obs_wdata = '0;
    logic [31:0] obs_rsp_data = '0;
    logic        obs_rsp_illegal = 1'b0;

    always @(negedge clk) begin
        if (csr_wr_o) begin
            obs_wr_cnt++;
            obs_waddr = csr_waddr_o;
            obs_wdata = csr_wdata_o;
        end
        if (rsp_valid_o) begin
            obs_rsp_data    = rsp_data_o;
            obs_rsp_illegal = rsp_illegal_o;
        end
        if (!rst_n) begin
            chk("rst req_ready", {31'd0, req_ready_o}, 32'd1);
            chk("rst csr_wr", {31'd0, csr_wr_o}, 32'd0);
            chk("rst rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
            chk("rst rsp_illegal", {31'd0, rsp_illegal_o}, 32'd0);
            chk("rst raddr", {20'd0, csr_raddr_o}, 32'd0);
            chk("rst waddr", {20'd0, csr_waddr_o}, 32'd0);
            chk("rst wdata", csr_wdata_o, 32'd0);
            chk("rst rsp_data", rsp_data_o, 32'd0);
        end else begin
            chk("req_ready", {31'd0, req_ready_o}, {31'd0, m_age == -1});
            chk("csr_wr", {31'd0, csr_wr_o}, {31'd0, (m_age == 2) && m_wr});
            chk("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, m_age == 3});
            if (m_age == 1) chk("raddr", {20'd0, csr_raddr_o}, {20'd0, m_addr});
            if (m_age == 2 && m_wr) begin
                chk("waddr", {20'd0, csr_waddr_o}, {20'd0, m_addr});
                chk("wdata", csr_wdata_o, m_new);
            end
            if (m_age == 3) begin
                chk("rsp_data", rsp_data_o, m_data);
                chk("rsp_illegal", {31'd0, rsp_illegal_o}, {31'd0, m_illegal});
            end
        end
    end

    // One request from idle; returns accept-to-rsp_valid latency in cycles.
    task automatic run_txn(input logic [1:0] op, input logic imm, input logic [11:0] addr,
                           input logic [31:0] rs1, input logic [4:0] zimm, input int hold,
                           output int lat);
        int cyc;
        bit got;
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_op_i = op; req_imm_i = imm; req_addr_i = addr;
        req_rs1_i = rs1; req_zimm_i = zimm; rsp_ready_i = 1'b0;
        cyc = 0;
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            req_valid_i = 1'b0;
            cyc++;
            @(negedge clk);
            if (rsp_valid_o) got = 1;
        end
        lat = got ? cyc : -1;
        if (!got) chk("rsp timeout", 32'd0, 32'd1);
        repeat (hold) @(posedge clk);
        #1 rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
        @(negedge clk);
        chk("idle after rsp", {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        int lat, snap;
        rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = 2'd0; req_imm_i = 1'b0;
        req_addr_i = '0; req_rs1_i = '0; req_zimm_i = '0; rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // CSRRW frm
        snap = obs_wr_cnt;
        run_txn(2'b01, 1'b0, 12'h002, 32'h5, 5'd1, 0, lat);
        chk("rw latency", lat, 32'd3);
        chk("rw wr count", obs_wr_cnt - snap, 32'd1);
        chk("rw waddr", {20'd0, obs_waddr}, 32'h002);
        chk("rw wdata", obs_wdata, 32'h5);
        chk("rw rsp_data", obs_rsp_data, 32'h0);

        // CSRRS fflags
        run_txn(2'b10, 1'b0, 12'h001, 32'h03, 5'd2, 1, lat);
        chk("rs wdata", obs_wdata, 32'h13);
        chk("rs rsp_data", obs_rsp_data, 32'h10);

        // CSRRCI fcsr
        run_txn(2'b11, 1'b1, 12'h003, 32'hFFFF_FFFF, 5'h1F, 0, lat);
        chk("rci wdata", obs_wdata, 32'hE0);
        chk("rci rsp_data", obs_rsp_data, 32'hFF);

        // Read-only counter via suppressed CSRRS
        snap = obs_wr_cnt;
        run_txn(2'b10, 1'b0, 12'hC00, 32'hFFFF_FFFF, 5'd0, 0, lat);
        chk("cycle no write", obs_wr_cnt - snap, 32'd0);
        chk("cycle rsp_data", obs_rsp_data, 32'h1234);
        chk("cycle illegal", {31'd0, obs_rsp_illegal}, 32'd0);

        // CSRRW to read-only space
        snap = obs_wr_cnt;
        run_txn(2'b01, 1'b0, 12'hC00, 32'h7, 5'd1, 0, lat);
`ifdef CSR_CTRL_RO_CHECK_EN
        chk("ro rw writes", obs_wr_cnt - snap, 32'd0);
        chk("ro rw illegal", {31'd0, obs_rsp_illegal}, 32'd1);
        chk("ro rw rsp_data", obs_rsp_data, 32'd0);
`else
        chk("ro rw writes", obs_wr_cnt - snap, 32'd1);
        chk("ro rw illegal", {31'd0, obs_rsp_illegal}, 32'd0);
        chk("ro rw rsp_data", obs_rsp_data, 32'h1234);
`endif

        // Reserved op
        snap = obs_wr_cnt;
        run_txn(2'b00, 1'b0, 12'h001, 32'h1, 5'd3, 0, lat);
        chk("op00 writes", obs_wr_cnt - snap, 32'd0);
        chk("op00 illegal", {31'd0, obs_rsp_illegal}, 32'd1);
        chk("op00 rsp_data", obs_rsp_data, 32'd0);

        // Held response: stability covered by the per-cycle compare
        run_txn(2'b10, 1'b1, 12'h001, 32'h0, 5'd0, 5, lat);
        chk("hold rsp_data", obs_rsp_data, 32'h13);

        // Reset during WRITE
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_op_i = 2'b01; req_imm_i = 1'b0; req_addr_i = 12'h002;
        req_rs1_i = 32'h9; req_zimm_i = 5'd1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        snap = obs_wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort wr", {31'd0, csr_wr_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort no write", obs_wr_cnt - snap, 32'd0);
        chk("abort idle", {31'd0, req_ready_o}, 32'd1);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            rst_n       = ($urandom_range(0, 299) != 0);
            req_valid_i = $urandom_range(0, 1);
            req_op_i    = 2'($urandom_range(0, 3));
            req_imm_i   = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0:       req_addr_i = 12'h001;
                1:       req_addr_i = 12'h002;
                2:       req_addr_i = 12'h003;
                3:       req_addr_i = 12'hC00;
                4:       req_addr_i = 12'hC05;
                default: req_addr_i = 12'($urandom);
            endcase
            req_rs1_i   = $urandom;
            req_zimm_i  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rsp_ready_i = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        repeat (6) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
